windower_feed_ctrl: RTL and testbench
=====================================

WINDOWER_FEED_CTRL -- requirements
Module: windower_feed_ctrl

Interface
REQ-001 SHALL have parameter IMG_SIZE, default 32: image height and width in pixels.
REQ-002 SHALL have parameter CH_IN, default 3: channels per pixel.
REQ-003 SHALL have parameter BW, default 16: bits per channel.
REQ-004 SHALL have parameter FIFO_DEPTH, default 1024: pixel buffer entries; SHALL be a power of 2 and >= IMG_SIZE*IMG_SIZE (elaboration error otherwise).
REQ-005 SHALL have port clock, input, 1: rising-edge clock.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port s_vld, input, 1: upstream pixel valid.
REQ-008 SHALL have port s_rdy, output, 1: upstream ready; equals !fifo_full.
REQ-009 SHALL have port s_data, input, CH_IN*BW: upstream pixel, raster order.
REQ-010 SHALL have port win_vld_in, output, 1: valid to windower.
REQ-011 SHALL have port win_in, output, CH_IN*BW: pixel to windower.
REQ-012 SHALL have port win_vld_out, input, 1: windower output valid.
REQ-013 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse per completed frame.
REQ-015 SHALL have port err_gap, output, 1: sticky; win_vld_out dropped mid-frame.

Function
REQ-016 SHALL accept a pixel on each cycle with s_vld & s_rdy; simultaneous push and pop SHALL leave the occupancy count unchanged.
REQ-017 SHALL implement FSM states IDLE, STREAM, DRAIN.
- IDLE -> STREAM when occupancy >= IMG_SIZE*IMG_SIZE.
- STREAM -> DRAIN after exactly IMG_SIZE*IMG_SIZE pops.
- DRAIN -> IDLE when the output window count reaches IMG_SIZE*IMG_SIZE and at least IMG_SIZE+3 drain cycles have elapsed.
REQ-018 In STREAM, SHALL pop one pixel per cycle with no bubbles; win_vld_in SHALL be high for exactly IMG_SIZE*IMG_SIZE consecutive cycles, starting the cycle after STREAM entry (registered output).
REQ-019 win_vld_in SHALL be low in IDLE and DRAIN; win_in SHALL hold its last value when win_vld_in is low.
REQ-020 SHALL count win_vld_out cycles per frame in a counter of width clog2(IMG_SIZE*IMG_SIZE)+1; frame_done SHALL pulse the cycle after the count reaches IMG_SIZE*IMG_SIZE, and the counter SHALL then clear.
REQ-021 err_gap SHALL set if win_vld_out is low on any cycle after the first window of a frame and before the last; it SHALL clear only on reset.
REQ-022 SHALL continue accepting upstream pixels in every state; back-to-back frames SHALL be separated only by the DRAIN interval.
REQ-023 When the FIFO is full, s_rdy SHALL deassert combinationally from the registered full flag; no pixel SHALL be lost or duplicated.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-025 Reset SHALL force state IDLE, FIFO empty, all counters 0, and win_vld_in, busy, frame_done and err_gap to 0; s_rdy SHALL read 1 the first cycle after reset.
REQ-026 Reset asserted mid-STREAM SHALL discard buffered pixels and deassert win_vld_in on the next edge.

Structure
REQ-027 State enum and derived constants (NPIX = IMG_SIZE*IMG_SIZE, DRAIN_MIN = IMG_SIZE+3) SHALL live in package twn_ctrl_pkg.
REQ-028 The pixel buffer SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count), inferring block RAM.

Verification (IMG_SIZE=4, CH_IN=1, BW=8, FIFO_DEPTH=32)
REQ-029 Push pixels 0..15 continuously -> win_vld_in is high for 16 consecutive cycles carrying 0..15 in order; with win_vld_out stubbed as a 7-cycle delay of win_vld_in, frame_done pulses once and err_gap stays 0.
REQ-030 Push 15 pixels, stall 20 cycles, push pixel 15 -> win_vld_in stays low until the 16th pixel is buffered, then issues 16 bubble-free cycles.
REQ-031 Push 32 pixels with s_vld held high -> s_rdy drops at occupancy 32; two frames stream, separated by at least 7 idle win_vld_in cycles; output data equals input order.
REQ-032 Stub drops win_vld_out for 1 cycle at window 8 -> err_gap is 1 and remains 1 until reset.
REQ-033 Assert reset at the 5th STREAM cycle -> next cycle win_vld_in=0 and busy=0; then push 16 new pixels -> a clean frame of exactly those 16 pixels.
REQ-034 Random s_vld (50%) over 5 frames -> scoreboard matches all 80 pixels in order, with exactly 5 frame_done pulses.

Source files
------------

// File: rtl/twn_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// twn_ctrl_pkg
// Shared types and derived constants for the windower feed controller.
//   feed_state_t : controller FSM encoding (IDLE / STREAM / DRAIN)
//   npix()       : pixels per frame, NPIX = IMG_SIZE*IMG_SIZE
//   drain_min()  : minimum drain interval, DRAIN_MIN = IMG_SIZE+3
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package twn_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } feed_state_t;

    // The image size is a module parameter, so the derived constants are
    // expressed as constant functions evaluated at elaboration time.
    function automatic int npix(input int img_size);
        return img_size * img_size;
    endfunction

    function automatic int drain_min(input int img_size);
        return img_size + 3;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO on an inferred block RAM with registered read data.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, din    : write request / data (ignored while full)
//   pop          : read request (ignored while empty); dout updates on the
//                  edge that performs the pop and holds otherwise
//   full, empty  : registered status flags
//   count        : registered occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] dout_q;
    logic             do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        // A simultaneous push and pop leaves the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array: write port only, no reset, so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

    // Registered read port; the output register holds between pops.
    always_ff @(posedge clock) begin
        if (reset)       dout_q <= '0;
        else if (do_pop) dout_q <= mem[rd_ptr_q];
    end

    assign dout  = dout_q;
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/windower_feed_ctrl.sv
// ---------------------------------------------------------------------------
// windower_feed_ctrl
// Buffers a raster pixel stream and feeds whole frames to a windower
// without bubbles, then waits for the windower to finish the frame.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   s_vld/s_rdy   : upstream handshake, s_data = pixel (CH_IN*BW bits)
//   win_vld_in    : registered valid to windower, win_in = pixel
//   win_vld_out   : windower output-valid (one per produced window)
//   busy          : controller not in IDLE
//   frame_done    : one-cycle pulse after the last window of a frame
//   err_gap       : sticky, windower output stalled inside a frame
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module windower_feed_ctrl
    import twn_ctrl_pkg::*;
#(
    parameter int IMG_SIZE   = 32,
    parameter int CH_IN      = 3,
    parameter int BW         = 16,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  s_vld,
    output logic                  s_rdy,
    input  logic [CH_IN*BW-1:0]   s_data,
    output logic                  win_vld_in,
    output logic [CH_IN*BW-1:0]   win_in,
    input  logic                  win_vld_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_gap
);
    localparam int NPIX      = npix(IMG_SIZE);
    localparam int DRAIN_MIN = drain_min(IMG_SIZE);
    localparam int DW        = CH_IN * BW;
    localparam int CW        = $clog2(NPIX) + 1;
    localparam int FCW       = $clog2(FIFO_DEPTH) + 1;
    localparam int DCW       = $clog2(DRAIN_MIN) + 1;

    generate
        if (((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (FIFO_DEPTH < NPIX)) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of two and at least IMG_SIZE*IMG_SIZE");
        end
    endgenerate

    feed_state_t    state_q, state_d;
    logic [CW-1:0]  pop_cnt_q, pop_cnt_d;
    logic [CW-1:0]  win_cnt_q, win_cnt_d;
    logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
    logic           win_done_q, win_done_d;
    logic           win_vld_in_q, win_vld_in_d;
    logic           frame_done_q, frame_done_d;
    logic           err_gap_q, err_gap_d;

    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FCW-1:0] fifo_count;
    logic [DW-1:0]  fifo_dout;
    logic           frame_hit;

    assign s_rdy     = !fifo_full;
    assign fifo_push = s_vld && s_rdy;

    sync_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (s_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Window count has reached a full frame; this is the frame_done cycle.
    assign frame_hit = (win_cnt_q == CW'(NPIX));

    always_comb begin
        state_d      = state_q;
        pop_cnt_d    = pop_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        win_done_d   = win_done_q | frame_hit;
        fifo_pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A whole frame is buffered, so STREAM can never starve.
                if (fifo_count >= FCW'(NPIX)) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                fifo_pop = !fifo_empty;
                if (pop_cnt_q == CW'(NPIX - 1)) begin
                    pop_cnt_d   = '0;
                    drain_cnt_d = '0;
                    state_d     = ST_DRAIN;
                end else begin
                    pop_cnt_d = pop_cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q != DCW'(DRAIN_MIN)) drain_cnt_d = drain_cnt_q + 1'b1;
                // drain_cnt_q counts DRAIN cycles before the current one.
                if ((win_done_q || frame_hit) && (drain_cnt_q >= DCW'(DRAIN_MIN - 1))) begin
                    state_d     = ST_IDLE;
                    drain_cnt_d = '0;
                    win_done_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Counter clears after the full-frame cycle; a window arriving in
        // that same cycle already belongs to the next frame.
        win_cnt_d = win_cnt_q;
        if (frame_hit)        win_cnt_d = CW'(win_vld_out);
        else if (win_vld_out) win_cnt_d = win_cnt_q + 1'b1;

        frame_done_d = (win_cnt_d == CW'(NPIX));
        err_gap_d    = err_gap_q | (!win_vld_out && (win_cnt_q != '0) && !frame_hit);
        // FIFO read data lands one edge after the pop, in step with this flag.
        win_vld_in_d = fifo_pop;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pop_cnt_q    <= '0;
            win_cnt_q    <= '0;
            drain_cnt_q  <= '0;
            win_done_q   <= 1'b0;
            win_vld_in_q <= 1'b0;
            frame_done_q <= 1'b0;
            err_gap_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pop_cnt_q    <= pop_cnt_d;
            win_cnt_q    <= win_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            win_done_q   <= win_done_d;
            win_vld_in_q <= win_vld_in_d;
            frame_done_q <= frame_done_d;
            err_gap_q    <= err_gap_d;
        end
    end

    assign win_vld_in = win_vld_in_q;
    assign win_in     = fifo_dout;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign err_gap    = err_gap_q;

endmodule

// File: tb/tb_windower_feed_ctrl.sv
`timescale 1ns/1ps
module tb_windower_feed_ctrl;
    localparam int NP    = 16;   // pixels per 4x4 frame
    localparam int DMIN  = 7;    // minimum drain interval for a 4x4 image
    localparam int DEPTH = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       s_vld = 1'b0;
    logic [7:0] s_data = 8'd0;
    logic       s_rdy, win_vld_in, win_vld_out, busy, frame_done, err_gap;
    logic [7:0] win_in;

    always #5 clock = ~clock;

    windower_feed_ctrl #(
        .IMG_SIZE(4), .CH_IN(1), .BW(8), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .s_vld(s_vld), .s_rdy(s_rdy), .s_data(s_data),
        .win_vld_in(win_vld_in), .win_in(win_in), .win_vld_out(win_vld_out),
        .busy(busy), .frame_done(frame_done), .err_gap(err_gap)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Windower stub: output valid is win_vld_in delayed by stub_lat cycles,
    // with an optional single lost window at absolute index drop_at.
    logic [63:0] dly;
    int          stub_lat = 7;
    int          win_total;
    bit          drop_en = 1'b0;
    int          drop_at = 0;
    logic        stub_tap;

    assign stub_tap    = dly[stub_lat-1];
    assign win_vld_out = stub_tap && !(drop_en && (win_total == drop_at));

    always @(posedge clock) begin
        if (reset) begin
            dly       <= '0;
            win_total <= 0;
        end else begin
            dly <= {dly[62:0], win_vld_in};
            if (stub_tap) win_total <= win_total + 1;
        end
    end

    // Reference model: pixels leave in the order accepted, in bubble-free
    // runs of one frame, and the buffer holds what was accepted minus what
    // was delivered.
    logic [7:0] sb_q[$];
    int  n_push = 0, n_pop = 0, run_len = 0, gap_len = 0, fd_cnt = 0, full_cyc = 0;
    bit  seen_run = 1'b0, prev_fd = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            sb_q.delete();
            n_push = 0; n_pop = 0; run_len = 0; gap_len = 0;
            seen_run = 1'b0; prev_fd = 1'b0;
        end else begin
            if (win_vld_in) begin
                check_eq("sb_has_pixel", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) check_eq("pixel", win_in, sb_q.pop_front());
                n_pop++;
                if (run_len == 0 && seen_run) check_eq("gap_ge_drain_min", gap_len >= DMIN, 1);
                run_len++;
                gap_len = 0;
            end else begin
                if (run_len != 0) begin
                    check_eq("run_len", run_len, NP);
                    seen_run = 1'b1;
                end
                run_len = 0;
                gap_len++;
            end
            check_eq("s_rdy", s_rdy, (n_push - n_pop) < DEPTH);
            if (!s_rdy) full_cyc++;
            if (frame_done) begin
                check_eq("fd_one_cycle", prev_fd, 0);
                fd_cnt++;
            end
            prev_fd = frame_done;
            if (s_vld && s_rdy) begin
                sb_q.push_back(s_data);
                n_push++;
            end
        end
    end

    // Called at #1 after a rising edge; returns #1 after the accepting edge.
    task automatic push_px(input logic [7:0] d);
        int guard = 0;
        s_vld  = 1'b1;
        s_data = d;
        while (!s_rdy && guard < 1000) begin
            @(posedge clock); #1;
            guard++;
        end
        check_eq("push_accepted", guard < 1000, 1);
        @(posedge clock); #1;
        s_vld = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (!(n_pop == n_push && !busy) && k < budget) begin
            @(posedge clock); #1;
            k++;
        end
        check_eq("idle_reached", k < budget, 1);
    endtask

    initial begin
        int fd0, fc0, k;

        // Reset state, sampled while reset is still held.
        @(posedge clock); #1;
        check_eq("rst_win_vld_in", win_vld_in, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_err_gap", err_gap, 0);
        check_eq("rst_s_rdy", s_rdy, 1);
        @(posedge clock); #1;
        reset = 1'b0;

        // Continuous frame 0..15.
        fd0 = fd_cnt;
        for (int i = 0; i < NP; i++) push_px(8'(i));
        wait_idle(500);
        check_eq("f1_frames", fd_cnt - fd0, 1);
        check_eq("f1_err_gap", err_gap, 0);
        $display("frame1: %0d pixels delivered, %0d frame_done", n_pop, fd_cnt - fd0);

        // 15 pixels, long stall, then the 16th.
        fd0 = fd_cnt;
        for (int i = 0; i < NP - 1; i++) push_px(8'($urandom));
        for (int i = 0; i < 20; i++) begin
            idle_cycles(1);
            check_eq("stall_no_vld", win_vld_in, 0);
        end
        push_px(8'($urandom));
        wait_idle(500);
        check_eq("f2_frames", fd_cnt - fd0, 1);
        $display("stalled frame: %0d pixels delivered, %0d frame_done", n_pop, fd_cnt - fd0);

        // Slow windower so the buffer fills; s_vld held high throughout.
        idle_cycles(70);
        stub_lat = 40;
        fd0 = fd_cnt;
        fc0 = full_cyc;
        for (int i = 0; i < 4 * NP; i++) push_px(8'($urandom));
        wait_idle(2000);
        check_eq("full_seen", full_cyc > fc0, 1);
        check_eq("f3_frames", fd_cnt - fd0, 4);
        check_eq("f3_err_gap", err_gap, 0);
        $display("backpressure: %0d frames, %0d full cycles", fd_cnt - fd0, full_cyc - fc0);
        stub_lat = 7;

        // Random upstream valid over five frames.
        fd0 = fd_cnt;
        for (int i = 0; i < 5 * NP; i++) begin
            while ($urandom_range(1, 0) == 0) idle_cycles(1);
            push_px(8'($urandom));
        end
        wait_idle(2000);
        check_eq("f4_frames", fd_cnt - fd0, 5);
        check_eq("f4_err_gap", err_gap, 0);
        $display("random valid: %0d frames", fd_cnt - fd0);

        // Windower loses window 8 of a frame.
        fd0 = fd_cnt;
        drop_at = win_total + 8;
        drop_en = 1'b1;
        for (int i = 0; i < NP; i++) push_px(8'($urandom));
        k = 0;
        while (!(n_pop == n_push && win_total >= drop_at + 8) && k < 500) begin
            idle_cycles(1);
            k++;
        end
        check_eq("drop_frame_sent", k < 500, 1);
        idle_cycles(3);
        check_eq("err_gap_set", err_gap, 1);
        check_eq("drop_busy", busy, 1);
        check_eq("drop_frames", fd_cnt - fd0, 0);
        idle_cycles(20);
        check_eq("err_gap_sticky", err_gap, 1);
        drop_en = 1'b0;
        reset = 1'b1;
        idle_cycles(1);
        check_eq("rst2_err_gap", err_gap, 0);
        check_eq("rst2_busy", busy, 0);
        check_eq("rst2_s_rdy", s_rdy, 1);
        reset = 1'b0;
        $display("gap fault: err_gap cleared by reset");

        // Reset in the 5th STREAM cycle, then one clean frame.
        for (int i = 0; i < NP; i++) push_px(8'($urandom));
        k = 0;
        while (!busy && k < 100) begin
            idle_cycles(1);
            k++;
        end
        check_eq("stream_entered", k < 100, 1);
        idle_cycles(4);
        reset = 1'b1;
        idle_cycles(1);
        check_eq("midrst_win_vld_in", win_vld_in, 0);
        check_eq("midrst_busy", busy, 0);
        reset = 1'b0;
        fd0 = fd_cnt;
        for (int i = 0; i < NP; i++) push_px(8'($urandom));
        wait_idle(500);
        check_eq("f5_frames", fd_cnt - fd0, 1);
        check_eq("f5_pixels", n_pop, NP);
        check_eq("f5_err_gap", err_gap, 0);
        $display("post-reset frame: %0d pixels delivered", n_pop);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
